// File: rtl/filter_preload_buffer.sv
// rtl/filter_preload_buffer.sv - Wishbone prefetch of filter words into a local single-cycle read buffer
module filter_preload_buffer #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [IDX_W:0]   num_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W:0]   valid_count,
    input  logic [IDX_W-1:0] rd_index,
    output logic [31:0]      rd_data,
    output logic             rd_hit,
    output logic [29:0]      wb_adr,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [3:0]       wb_sel,
    output logic [2:0]       wb_cti,
    output logic [1:0]       wb_bte,
    input  logic [31:0]      wb_dat_miso,
    input  logic             wb_ack,
    input  logic             wb_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W:0]   r_len;
    logic [IDX_W:0]   r_vc;
    logic [29:0]      r_adr;
    logic             r_err;
    logic [31:0]      r_rd_data;
    logic             r_rd_hit;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic [IDX_W:0]   w_len;
    logic [IDX_W:0]   w_vc_inc;
    logic             w_wr;
    logic             w_unused_adr_lsb;

    // Oversize requests are clipped to the buffer capacity.
    assign w_len    = (num_words > (IDX_W+1)'(DEPTH_WORDS)) ? (IDX_W+1)'(DEPTH_WORDS) : num_words;
    assign w_vc_inc = r_vc + (IDX_W+1)'(1);
    assign w_wr     = (r_state == FETCH) && wb_ack && !wb_err;
    assign w_unused_adr_lsb = ^base_adr[1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (w_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (wb_err) begin
                    w_next = IDLE;
                end else if (wb_ack && (w_vc_inc == r_len)) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_vc    <= '0;
            r_adr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len <= w_len;
                        r_err <= 1'b0;
                        r_vc  <= '0;
                        r_adr <= base_adr[31:2];
                    end
                end
                FETCH: begin
                    // A bus error wins over a simultaneous ack: nothing is counted or written.
                    if (wb_err) begin
                        r_err <= 1'b1;
                    end else if (wb_ack) begin
                        r_vc  <= w_vc_inc;
                        r_adr <= r_adr + 30'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_vc[IDX_W-1:0]] <= wb_dat_miso;
        end
    end

    // Read port runs independently of the fetch; a same-cycle write returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
            r_rd_hit  <= 1'b0;
        end else begin
            r_rd_data <= r_mem[rd_index];
            r_rd_hit  <= ({1'b0, rd_index} < r_vc);
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign err         = r_err;
    assign valid_count = r_vc;
    assign rd_data     = r_rd_data;
    assign rd_hit      = r_rd_hit;
    assign wb_adr      = r_adr;
    assign wb_cyc      = (r_state == FETCH);
    assign wb_stb      = (r_state == FETCH);
    assign wb_we       = 1'b0;
    assign wb_sel      = 4'b1111;
    assign wb_cti      = 3'b000;
    assign wb_bte      = 2'b00;

endmodule

// File: tb/tb_filter_preload_buffer.sv
// tb/tb_filter_preload_buffer.sv - directed bench for filter_preload_buffer with a Wishbone slave model
module tb_filter_preload_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_adr = '0;
    logic [8:0]  num_words = '0;
    logic        busy, done, err, rd_hit;
    logic [8:0]  valid_count;
    logic [7:0]  rd_index = '0;
    logic [31:0] rd_data;
    logic [29:0] wb_adr;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_miso = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    filter_preload_buffer #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_adr(base_adr),
        .num_words(num_words), .busy(busy), .done(done), .err(err),
        .valid_count(valid_count), .rd_index(rd_index), .rd_data(rd_data),
        .rd_hit(rd_hit), .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_dat_miso(wb_dat_miso), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave control (written only by the stimulus process)
    int   ack_every = 1;
    int   err_at    = 0;
    bit   force_ack = 1'b0;
    bit   clr       = 1'b0;
    // Slave state (written only by the slave process)
    int   wcnt = 0;
    int   xfer = 0;
    int   acks = 0;
    bit   cyc_seen = 1'b0;
    longint t_ack3 = 0;
    logic [29:0] adr_log [512];

    always @(negedge clk) begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        if (clr) begin
            wcnt = 0; xfer = 0; acks = 0; cyc_seen = 1'b0; t_ack3 = 0;
        end else if (force_ack) begin
            wb_ack = 1'b1;
        end else if (wb_cyc) begin
            cyc_seen = 1'b1;
            wcnt++;
            if (wcnt >= ack_every) begin
                wcnt = 0;
                xfer++;
                if (xfer == err_at) begin
                    wb_err = 1'b1;
                end else begin
                    wb_ack = 1'b1;
                    wb_dat_miso = {2'b00, wb_adr} * 32'd3;
                    if (acks < 512) adr_log[acks] = wb_adr;
                    acks++;
                    if (acks == 3) t_ack3 = $time;
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [8:0] n);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        base_adr  = base;
        num_words = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    longint t_hit;
    logic [31:0] hit_data;

    // Counts cycles from the start edge (=1) until busy drops; optional ignored start pulse.
    task automatic run(input int pulse_at, output int done_cyc, output int end_cyc);
        int cyc;
        cyc = 1;
        done_cyc = 0;
        t_hit = 0;
        hit_data = '0;
        while (cyc < 3000) begin
            if (done && done_cyc == 0) done_cyc = cyc;
            if (rd_hit && t_hit == 0) begin
                t_hit = $time;
                hit_data = rd_data;
            end
            if (!busy) break;
            if (cyc == pulse_at) begin
                base_adr  = 32'h9000;
                num_words = 9'd2;
                start     = 1'b1;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        if (cyc >= 3000) chk("timeout", 32'(cyc), 32'd0);
        end_cyc = cyc;
    endtask

    task automatic rd(input logic [7:0] idx, output logic [31:0] d, output logic h);
        rd_index = idx;
        tick();
        d = rd_data;
        h = rd_hit;
    endtask

    int dc, ec;
    logic [31:0] d;
    logic h;

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cyc", 32'({wb_cyc, wb_stb}), 32'd0);
        chk("rst_adr", 32'(wb_adr), 32'd0);
        chk("rst_vc", 32'(valid_count), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_hit", 32'(rd_hit), 32'd0);
        chk("ties", {wb_we, wb_sel, wb_cti, wb_bte}, 32'h1E0);
        reset = 1'b0;
        tick();

        // Basic load, zero wait states
        ack_every = 1; err_at = 0;
        do_start(32'h1000, 9'd4);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_cyc", 32'(wb_cyc & wb_stb), 32'd1);
        run(0, dc, ec);
        chk("basic_done_cyc", 32'(dc), 32'd5);
        chk("basic_vc", 32'(valid_count), 32'd4);
        chk("basic_acks", 32'(acks), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_adr%0d", i), 32'(adr_log[i]), 32'h400 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            rd(8'(i), d, h);
            chk($sformatf("basic_rd%0d", i), d, 32'hC00 + 32'(3 * i));
            chk($sformatf("basic_hit%0d", i), 32'(h), 32'd1);
        end
        rd(8'd4, d, h);
        chk("basic_miss", 32'(h), 32'd0);

        // Zero length
        do_start(32'h4000, 9'd0);
        run(0, dc, ec);
        chk("zero_done_cyc", 32'(dc), 32'd1);
        chk("zero_no_cyc", 32'(cyc_seen), 32'd0);
        chk("zero_vc", 32'(valid_count), 32'd0);

        // Wait states with early use of word 2
        ack_every = 3;
        rd_index = 8'd2;
        do_start(32'h2000, 9'd8);
        run(0, dc, ec);
        chk("ws_hit_delay", 32'(t_hit - t_ack3), 32'd21);
        chk("ws_hit_data", hit_data, 32'h1806);
        chk("ws_vc", 32'(valid_count), 32'd8);
        chk("ws_done_cyc", 32'(dc), 32'd25);
        chk("ws_adr7", 32'(adr_log[7]), 32'h807);

        // Oversize request clipped to 256
        ack_every = 1;
        do_start(32'h0, 9'd300);
        run(0, dc, ec);
        chk("big_acks", 32'(acks), 32'd256);
        chk("big_vc", 32'(valid_count), 32'd256);
        chk("big_done_cyc", 32'(dc), 32'd257);
        rd(8'd255, d, h);
        chk("big_rd255", d, 32'h2FD);
        chk("big_hit255", 32'(h), 32'd1);

        // Bus error on third transfer
        err_at = 3;
        do_start(32'h3000, 9'd6);
        run(0, dc, ec);
        chk("err_end_cyc", 32'(ec), 32'd4);
        chk("err_no_done", 32'(dc), 32'd0);
        chk("err_flag", 32'(err), 32'd1);
        chk("err_vc", 32'(valid_count), 32'd2);
        chk("err_cyc", 32'(wb_cyc), 32'd0);
        err_at = 0;
        do_start(32'h3000, 9'd1);
        chk("err_clear", 32'(err), 32'd0);
        run(0, dc, ec);
        chk("err_recover_done", 32'(dc), 32'd2);

        // Ignored start mid-fetch
        do_start(32'h5000, 9'd10);
        run(3, dc, ec);
        chk("ign_done_cyc", 32'(dc), 32'd11);
        chk("ign_vc", 32'(valid_count), 32'd10);
        chk("ign_adr9", 32'(adr_log[9]), 32'h1409);

        // Reset during word 5 of 10
        do_start(32'h6000, 9'd10);
        for (int i = 0; i < 50 && acks < 5; i++) tick();
        chk("abort_acks", 32'(acks), 32'd5);
        reset = 1'b1;
        #1;
        chk("abort_cyc", 32'({wb_cyc, wb_stb}), 32'd0);
        chk("abort_vc", 32'(valid_count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        force_ack = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        force_ack = 1'b0;
        chk("abort_idle", 32'({busy, wb_cyc}), 32'd0);
        rd(8'd4, d, h);
        chk("abort_rd4_old", d, 32'h3C0C);
        chk("abort_hit4", 32'(h), 32'd0);
        rd(8'd0, d, h);
        chk("abort_rd0_new", d, 32'h4800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filter_preload_buffer.md
# filter_preload_buffer

Wishbone-master prefetch engine that copies a contiguous block of 32-bit filter words from system RAM into a local on-chip buffer before a convolution pass. It sits directly upstream of the convolution CFU datapath. Once a filter is loaded, the four int8 filter taps per word are served from a single-cycle local read port instead of a RAM round-trip per word. The CPU programs the base byte address and word count, pulses `start`, and polls `busy`/`done`/`err`.

## Interface

Parameters:
- `DEPTH_WORDS`, default 256: buffer capacity in 32-bit words; must be a power of two.
- `IDX_W`, default 8: index width, equal to log2(`DEPTH_WORDS`).

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request a load; sampled only in IDLE.
- `base_adr`, input, 32: byte address of the first word; bits [1:0] are ignored.
- `num_words`, input, IDX_W+1: number of words to load.
- `busy`, output, 1: high in every state other than IDLE.
- `done`, output, 1: one-cycle pulse when a load completes successfully.
- `err`, output, 1: sticky flag set by a bus error; cleared by the next accepted `start`.
- `valid_count`, output, IDX_W+1: number of words written so far in the current load.
- `rd_index`, input, IDX_W: local read address.
- `rd_data`, output, 32: buffer word at `rd_index`, registered, one-cycle latency.
- `rd_hit`, output, 1: registered; high when the `rd_index` sampled on the prior edge was less than `valid_count`.
- `wb_adr`, output, 30: Wishbone word address.
- `wb_cyc`, output, 1: Wishbone cycle.
- `wb_stb`, output, 1: Wishbone strobe.
- `wb_we`, output, 1: tied 0.
- `wb_sel`, output, 4: tied 4'b1111.
- `wb_cti`, output, 3: tied 0.
- `wb_bte`, output, 2: tied 0.
- `wb_dat_miso`, input, 32: Wishbone read data.
- `wb_ack`, input, 1: Wishbone acknowledge.
- `wb_err`, input, 1: Wishbone error.

## Operation

- States: IDLE, FETCH, DONE.
- Reset values: state IDLE. `busy`, `done`, `err`, `wb_cyc`, `wb_stb`, `rd_hit` = 0. `wb_adr`, `valid_count`, `rd_data` = 0. Buffer contents are not reset.

IDLE:
- On `start`, latch `len = min(num_words, DEPTH_WORDS)`, clear `err`, `valid_count` <= 0, and latch `wb_adr` <= `base_adr[31:2]`.
- If `len == 0`, go to DONE; otherwise go to FETCH.

FETCH:
- `wb_cyc` = `wb_stb` = 1.
- On `wb_ack`:
  - `mem[valid_count]` <= `wb_dat_miso`.
  - `valid_count` increments.
  - `wb_adr` increments, wrapping modulo 2^30.
  - If `valid_count + 1 == len`, go to DONE.
- On `wb_err` (priority over `wb_ack` in the same cycle): drop `wb_cyc`/`wb_stb`, set `err`, write nothing, go to IDLE. `done` does not pulse; `valid_count` retains the number of good words.

DONE:
- `wb_cyc` = `wb_stb` = 0, `done` = 1, then go to IDLE.

Other rules:
- `start` outside IDLE is ignored.
- The read port is independent of the fetch. Reading an index while it is being written in the same cycle returns the old data.
- `rd_hit` lets the consumer begin using leading words before the load finishes.
- Reset asserted mid-FETCH immediately drops `wb_cyc`/`wb_stb`. Any `wb_ack` arriving after reset is ignored.

## Timing

- `wb_cyc`/`wb_stb` rise on the edge after `start` is accepted. They stay high continuously through FETCH; there are no idle gaps between words.
- `wb_adr` updates on the edge where `wb_ack` is sampled. The slave sees the next address in the following cycle.
- Load time with a zero-wait-state slave (ack every cycle): `start` edge, then `len` FETCH cycles, then 1 DONE cycle. `done` is high exactly `len+1` cycles after the `start` edge. With `len == 0`, `done` is high 1 cycle after.
- `busy` is high from the edge after `start` through the DONE cycle inclusive.
- `rd_data` and `rd_hit` are valid on the clock edge after `rd_index` is presented.

## Test plan

- Basic load: base 0x1000, 4 words, slave acks every cycle returning `adr*3` → `wb_adr` sequence 0x400–0x403, `done` at cycle 5, and reads of idx 0–3 return 0xC00, 0xC03, 0xC06, 0xC09.
- Wait states and early use: 8 words, slave acks every third cycle; read idx 2 while loading → `rd_hit` stays 0 until `valid_count` > 2 and data then matches; `valid_count` = 8 at `done`.
- Zero length and oversize: `num_words` = 0 → `done` 1 cycle after `start` with no `wb_cyc`. `num_words` = 300 → exactly 256 acks consumed.
- Bus error: 6 words with `wb_err` on the 3rd transfer → `err` = 1, no `done`, `valid_count` = 2, bus released the next cycle. A subsequent `start` clears `err`.
- Ignored start and reset abort: pulse `start` mid-FETCH → no effect. Assert reset during word 5 of 10 → `wb_cyc`/`wb_stb` low immediately, `valid_count` = 0, and a late `wb_ack` causes no write.
